// File: rtl/blackjack_pkg.sv
// Shared deck constants, dealer FSM states and the decoded card record.
package blackjack_pkg;

  localparam int DECK_SIZE = 52;
  localparam int RANKS     = 13;

  typedef enum logic {
    IDLE  = 1'b0,
    PROBE = 1'b1
  } dealer_state_t;

  typedef struct packed {
    logic [3:0] rank;
    logic [1:0] suit;
    logic [3:0] points;
  } card_t;

endpackage

// File: rtl/card_index_decode.sv
// Combinational map from deck index (suit*13 + rank-1) to rank, suit and blackjack points.
module card_index_decode
  import blackjack_pkg::*;
#(
  parameter int ACE_POINTS = 1
) (
  input  logic [5:0] i_idx,
  output card_t      o_card
);

  localparam logic [5:0] SUIT1_BASE = 6'(RANKS);
  localparam logic [5:0] SUIT2_BASE = 6'(2 * RANKS);
  localparam logic [5:0] SUIT3_BASE = 6'(3 * RANKS);
  localparam logic [3:0] ACE_PTS    = 4'(ACE_POINTS);

  logic [1:0] w_suit;
  logic [5:0] w_base;
  logic [3:0] w_rank;
  logic [3:0] w_points;

  // Compare chain instead of a divider: only four suit bases exist.
  always_comb begin
    w_suit = 2'd0;
    w_base = 6'd0;
    if (i_idx >= SUIT3_BASE) begin
      w_suit = 2'd3;
      w_base = SUIT3_BASE;
    end else if (i_idx >= SUIT2_BASE) begin
      w_suit = 2'd2;
      w_base = SUIT2_BASE;
    end else if (i_idx >= SUIT1_BASE) begin
      w_suit = 2'd1;
      w_base = SUIT1_BASE;
    end
  end

  assign w_rank = 4'(i_idx - w_base + 6'd1);

  always_comb begin
    w_points = w_rank;
    if (w_rank == 4'd1) begin
      w_points = ACE_PTS;
    end else if (w_rank >= 4'd10) begin
      w_points = 4'd10;
    end
  end

  assign o_card.rank   = w_rank;
  assign o_card.suit   = w_suit;
  assign o_card.points = w_points;

endmodule

// File: rtl/card_dealer.sv
// Deals cards from a 52-card deck without repeats; collisions resolved by linear probe.
module card_dealer
  import blackjack_pkg::*;
#(
  parameter int ACE_POINTS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       shuffle,
  input  logic       draw_req,
  input  logic [5:0] rand_value,
  output logic       busy,
  output logic       card_valid,
  output logic [3:0] card_rank,
  output logic [1:0] card_suit,
  output logic [3:0] card_points,
  output logic [5:0] cards_left,
  output logic       deck_empty,
  output logic       draw_err
);

  localparam logic [5:0] FULL_DECK = 6'(DECK_SIZE);
  localparam logic [5:0] LAST_IDX  = 6'(DECK_SIZE - 1);

  dealer_state_t r_state;
  dealer_state_t w_next_state;

  logic [DECK_SIZE-1:0] r_used;
  logic [5:0]           r_cards_left;
  logic [5:0]           r_idx;
  logic                 r_card_valid;
  logic                 r_draw_err;
  card_t                r_card;

  logic       w_load_idx;
  logic       w_step_idx;
  logic       w_take;
  logic       w_err;
  logic       w_slot_free;
  logic       w_deck_empty;
  logic [5:0] w_start_idx;
  card_t      w_card;

  card_index_decode #(
    .ACE_POINTS(ACE_POINTS)
  ) u_decode (
    .i_idx (r_idx),
    .o_card(w_card)
  );

  assign w_deck_empty = (r_cards_left == 6'd0);
  assign w_slot_free  = ~r_used[r_idx];
  assign w_start_idx  = (rand_value >= FULL_DECK) ? (rand_value - FULL_DECK) : rand_value;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Shuffle overrides everything: a pending probe is dropped without a strobe.
  always_comb begin
    w_next_state = r_state;
    w_load_idx   = 1'b0;
    w_step_idx   = 1'b0;
    w_take       = 1'b0;
    w_err        = 1'b0;
    if (shuffle) begin
      w_next_state = IDLE;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (draw_req) begin
            if (w_deck_empty) begin
              w_err = 1'b1;
            end else begin
              w_load_idx   = 1'b1;
              w_next_state = PROBE;
            end
          end
        end
        PROBE: begin
          if (w_slot_free) begin
            w_take       = 1'b1;
            w_next_state = IDLE;
          end else begin
            w_step_idx = 1'b1;
          end
        end
        default: w_next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_used       <= '0;
      r_cards_left <= FULL_DECK;
      r_idx        <= 6'd0;
      r_card_valid <= 1'b0;
      r_draw_err   <= 1'b0;
      r_card       <= '0;
    end else begin
      r_card_valid <= w_take;
      r_draw_err   <= w_err;

      if (shuffle) begin
        r_used       <= '0;
        r_cards_left <= FULL_DECK;
      end else if (w_take) begin
        r_used[r_idx] <= 1'b1;
        r_cards_left  <= r_cards_left - 6'd1;
        r_card        <= w_card;
      end

      if (w_load_idx) begin
        r_idx <= w_start_idx;
      end else if (w_step_idx) begin
        r_idx <= (r_idx == LAST_IDX) ? 6'd0 : (r_idx + 6'd1);
      end
    end
  end

  assign busy        = (r_state == PROBE);
  assign card_valid  = r_card_valid;
  assign card_rank   = r_card.rank;
  assign card_suit   = r_card.suit;
  assign card_points = r_card.points;
  assign cards_left  = r_cards_left;
  assign deck_empty  = w_deck_empty;
  assign draw_err    = r_draw_err;

  // The probe only terminates if a free card exists when it starts.
  a_probe_has_card : assert property (
    @(posedge clk) disable iff (reset)
    (w_load_idx && !shuffle) |-> (r_cards_left != 6'd0)
  );

endmodule

// File: doc/card_dealer.md
# card_dealer

Draws cards from a single 52-card deck without repeats and hands each one to the hand/score logic. Sits directly downstream of the free-running `counter` (TOP = 51): that counter's `value` is sampled as the random draw index. Collisions with already-dealt cards are resolved by a deterministic linear probe. Outputs are rank, suit and blackjack point value, with a one-cycle valid strobe.

## Interface
- `ACE_POINTS`, default 1: point value reported for an ace; legal values are 1 or 11.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `shuffle` in 1: restore all 52 cards to the deck.
- `draw_req` in 1: request one card; sampled only when `busy` = 0.
- `rand_value` in 6: draw seed, normally driven by the upstream counter `value`.
- `busy` out 1: a draw is in progress; new `draw_req` is ignored.
- `card_valid` out 1: one-cycle strobe; card fields are valid while it is high.
- `card_rank` out 4: 1..13 (A, 2..10, J, Q, K).
- `card_suit` out 2: 0..3.
- `card_points` out 4: 2..10 per rank; J/Q/K = 10; ace = `ACE_POINTS`.
- `cards_left` out 6: 0..52.
- `deck_empty` out 1: high when `cards_left` == 0.
- `draw_err` out 1: one-cycle pulse when a draw is requested on an empty deck.

## Operation
- Deck state: 52-bit `used` mask plus a 6-bit `cards_left` counter.
- Card index i = suit*13 + (rank-1), so suit = i/13 and rank = i%13 + 1.
- FSM has two states, IDLE and PROBE.
- IDLE, on `draw_req` with `deck_empty` = 0:
  - Load `idx` = `rand_value`, or `rand_value` − 52 if `rand_value` ≥ 52.
  - Go to PROBE.
- IDLE, on `draw_req` with `deck_empty` = 1: pulse `draw_err` next cycle and stay in IDLE.
- PROBE, `used[idx]` = 0:
  - Set `used[idx]` and decrement `cards_left`.
  - Register the rank/suit/points outputs and assert `card_valid` for one cycle.
  - Return to IDLE.
- PROBE, `used[idx]` = 1: `idx` ← (`idx` == 51) ? 0 : `idx`+1; stay in PROBE.
- Termination: PROBE always finds a free card, because PROBE is only entered with `cards_left` ≥ 1.
- `shuffle` has priority over every other event:
  - Clears `used` and sets `cards_left` = 52 on the next edge.
  - Forces IDLE.
  - An in-flight probe is aborted; no `card_valid` and no decrement occur.
  - `shuffle` and `draw_req` together in IDLE: the draw is dropped silently, with no `draw_err`.
- `draw_req` while `busy` = 1: ignored, not queued.
- Card outputs hold their last value between strobes.

## Timing
- Reset values:
  - `used` = 0, `cards_left` = 52, state IDLE.
  - `busy` = 0, `card_valid` = 0, `draw_err` = 0, `deck_empty` = 0.
  - `card_rank` = 0, `card_suit` = 0, `card_points` = 0.
- Reset mid-probe behaves exactly like `shuffle`.
- Request accepted in cycle N:
  - `busy` is high from N+1.
  - `card_valid` is high in cycle N+2+k, where k = number of used slots skipped (0..51).
  - `busy` is low in that same cycle, and a new request may be accepted in it.
- `cards_left`, `deck_empty` and `used` update on the same edge that raises `card_valid`.
- `draw_err` is high in cycle N+1 only.
- `rand_value` is sampled only in the accept cycle. Later changes to it do not affect the draw.

## Structure
- `blackjack_pkg` holds:
  - `DECK_SIZE` = 52 and `RANKS` = 13.
  - The state enum `dealer_state_t` {IDLE, PROBE}.
  - The struct `card_t` {rank[3:0], suit[1:0], points[3:0]}.
- Sub-module `card_index_decode`: combinational, maps a 6-bit index to `card_t` and is parameterised by `ACE_POINTS`.
- `card_dealer` itself holds the FSM, the `used` mask, `cards_left` and the output registers.

## Test plan
- Reset, then idle 5 cycles → `cards_left` = 52, `busy` = 0, `card_valid` = 0, `deck_empty` = 0.
- Fresh deck, `rand_value` = 0, draw at N → `card_valid` at N+2 with rank 1, suit 0, points 1 (11 with `ACE_POINTS` = 11); then `cards_left` = 51.
- Collision: two draws with `rand_value` = 12:
  - Second draw → index 13, rank 1, suit 1.
  - `card_valid` at N+3.
  - `rand_value` = 60 on a fresh deck → index 8: rank 9, suit 0, points 9.
- Wrap: after drawing index 51, a draw with `rand_value` = 51 → wraps to index 0 (rank 1, suit 0). A draw with rank 12 reports points 10.
- Exhaustion:
  - 52 draws with random `rand_value` → all 52 indices appear exactly once and `deck_empty` = 1.
  - 53rd draw → `draw_err` pulse, no `card_valid`.
  - `shuffle` → `cards_left` = 52.
- Abort: with 51 cards used, the remaining card at index 0, and `rand_value` = 1, assert `shuffle` in the first PROBE cycle → no `card_valid`, `busy` = 0 next cycle, `cards_left` = 52.
